// File: rtl/sr_ctrl_pkg.sv
// Shared encodings and sizing helpers for SR flag controllers.
package sr_ctrl_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    // Grant-id width; a single requester still needs one bit.
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GIDW_DEF = gid_w(4);

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester/flag-bank bus for sr_flag_arbiter.
interface sr_flag_arbiter_if
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 16,
    parameter int IDXW   = 4
);
    localparam int GIDW = gid_w(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_sr;
    logic [IDXW*NREQ-1:0] req_idx;
    logic                 clr_all;
    logic [NFLAGS-1:0]    flag_q;
    logic [NFLAGS-1:0]    flag_qn;
    logic                 grant_valid;
    logic [GIDW-1:0]      grant_id;
    logic                 err;
    logic [GIDW-1:0]      err_id;

    modport master (
        output req_valid, req_sr, req_idx, clr_all,
        input  req_ready, flag_q, flag_qn, grant_valid, grant_id, err, err_id
    );

    modport slave (
        input  req_valid, req_sr, req_idx, clr_all,
        output req_ready, flag_q, flag_qn, grant_valid, grant_id, err, err_id
    );

endinterface

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Combinational round-robin picker; the caller owns the pointer register.
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = gid_w(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_gnt_id
);

    logic [N-1:0] w_hi;

    always_comb begin
        w_hi     = '0;
        o_gnt    = '0;
        o_gnt_id = '0;
        for (int i = 0; i < N; i++)
            w_hi[i] = (W'(i) >= i_ptr) & i_req[i];
        // Lowest request at/above the pointer wins; otherwise wrap to lowest overall.
        if (|w_hi) begin
            for (int i = N - 1; i >= 0; i--)
                if (w_hi[i]) o_gnt_id = W'(i);
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (i_req[i]) o_gnt_id = W'(i);
        end
        if (|i_req)
            for (int i = 0; i < N; i++)
                o_gnt[i] = (o_gnt_id == W'(i));
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared SR flag bank with round-robin command arbitration and illegal-command reporting.
module sr_flag_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 16,
    parameter int IDXW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    sr_flag_arbiter_if.slave   bus
);

    localparam int GIDW = gid_w(NREQ);

    logic [NFLAGS-1:0] r_flag;
    logic [GIDW-1:0]   r_ptr;
    logic [GIDW-1:0]   r_gid;
    logic [GIDW-1:0]   r_eid;
    logic              r_gv;
    logic              r_err;

    logic [NREQ-1:0]   w_req;
    logic [NREQ-1:0]   w_gnt;
    logic [GIDW-1:0]   w_gid;
    logic [1:0]        w_sr;
    logic [IDXW-1:0]   w_idx;
    logic [NFLAGS-1:0] w_hit;
    logic              w_fire;
    logic              w_oor;
    logic              w_bad;

    // clr_all starves every requester for the cycle it is asserted.
    assign w_req = bus.req_valid & {NREQ{~bus.clr_all}};

    rr_arbiter #(.N(NREQ), .W(GIDW)) u_rr (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gid)
    );

    assign bus.req_ready = w_gnt & {NREQ{rst}};
    assign w_fire        = |bus.req_ready;

    always_comb begin
        w_sr  = SR_HOLD;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) begin
                w_sr  = bus.req_sr[2*i +: 2];
                w_idx = bus.req_idx[IDXW*i +: IDXW];
            end
        for (int f = 0; f < NFLAGS; f++)
            w_hit[f] = (w_idx == IDXW'(f));
    end

    // No decoded flag means the index lies beyond the bank.
    assign w_oor = ~|w_hit;
    assign w_bad = w_oor | (w_sr == SR_ILLEGAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flag <= '0;
            r_ptr  <= '0;
            r_gid  <= '0;
            r_eid  <= '0;
            r_gv   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_gv  <= w_fire;
            r_err <= w_fire & w_bad;
            if (w_fire) begin
                r_gid <= w_gid;
                r_ptr <= (w_gid == GIDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
                if (w_bad) r_eid <= w_gid;
            end
            if (bus.clr_all)
                r_flag <= '0;
            else if (w_fire && !w_bad) begin
                if (w_sr == SR_SET)        r_flag <= r_flag | w_hit;
                else if (w_sr == SR_RESET) r_flag <= r_flag & ~w_hit;
            end
        end
    end

    assign bus.flag_q      = r_flag;
    assign bus.flag_qn     = ~r_flag;
    assign bus.grant_valid = r_gv;
    assign bus.grant_id    = r_gid;
    assign bus.err         = r_err;
    assign bus.err_id      = r_eid;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench: a 16-flag bank plus a 12-flag bank for the out-of-range case.
module tb_sr_flag_arbiter;
    import sr_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(4), .NFLAGS(16), .IDXW(4)) b0 ();
    sr_flag_arbiter_if #(.NREQ(4), .NFLAGS(12), .IDXW(4)) b1 ();

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(16), .IDXW(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    sr_flag_arbiter #(.NREQ(4), .NFLAGS(12), .IDXW(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int r, input logic v, input logic [1:0] sr, input logic [3:0] idx);
        b0.req_valid[r]      = v;
        b0.req_sr[2*r +: 2]  = sr;
        b0.req_idx[4*r +: 4] = idx;
    endtask

    task automatic set1(input int r, input logic v, input logic [1:0] sr, input logic [3:0] idx);
        b1.req_valid[r]      = v;
        b1.req_sr[2*r +: 2]  = sr;
        b1.req_idx[4*r +: 4] = idx;
    endtask

    initial begin
        b0.req_valid = '0; b0.req_sr = '0; b0.req_idx = '0; b0.clr_all = 1'b0;
        b1.req_valid = '0; b1.req_sr = '0; b1.req_idx = '0; b1.clr_all = 1'b0;

        // reset state, with a requester already waiting
        set0(0, 1'b1, SR_SET, 4'd3);
        #3;
        chk("rst_q",     b0.flag_q, 64'h0);
        chk("rst_qn",    b0.flag_qn, 64'hFFFF);
        chk("rst_gv",    b0.grant_valid, 0);
        chk("rst_gid",   b0.grant_id, 0);
        chk("rst_err",   b0.err, 0);
        chk("rst_eid",   b0.err_id, 0);
        chk("rst_ready", b0.req_ready, 0);

        // single command
        tick();
        rst = 1'b1;
        #1;
        chk("first_ready", b0.req_ready, 4'b0001);
        tick();
        chk("first_q",   b0.flag_q, 64'h0008);
        chk("first_qn",  b0.flag_qn, 64'hFFF7);
        chk("first_gv",  b0.grant_valid, 1);
        chk("first_gid", b0.grant_id, 0);
        set0(0, 1'b0, SR_HOLD, 4'd0);

        // async reset pulse between edges returns the pointer to 0
        rst = 1'b0;
        #1;
        chk("pulse_q", b0.flag_q, 64'h0);
        rst = 1'b1;

        // round-robin fairness
        for (int r = 0; r < 4; r++) set0(r, 1'b1, SR_SET, 4'(r));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", b0.req_ready, 64'(1 << k));
            tick();
            chk("rr_gid", b0.grant_id, 64'(k));
            set0(k, 1'b0, SR_HOLD, 4'd0);
        end
        chk("rr_q", b0.flag_q, 64'h000F);

        set0(0, 1'b1, SR_RESET, 4'd0);
        set0(3, 1'b1, SR_HOLD, 4'd0);
        #1;
        chk("wrap_ready", b0.req_ready, 4'b0001);
        tick();
        chk("wrap_q", b0.flag_q, 64'h000E);
        set0(0, 1'b0, SR_HOLD, 4'd0);
        #1;
        chk("hold_ready", b0.req_ready, 4'b1000);
        tick();
        chk("hold_gid", b0.grant_id, 3);
        chk("hold_err", b0.err, 0);
        chk("hold_q",   b0.flag_q, 64'h000E);
        set0(3, 1'b0, SR_HOLD, 4'd0);

        // illegal command on a set flag
        set0(1, 1'b1, SR_SET, 4'd5);
        tick();
        chk("set5_q", b0.flag_q, 64'h002E);
        set0(1, 1'b0, SR_HOLD, 4'd0);
        set0(2, 1'b1, SR_ILLEGAL, 4'd5);
        #1;
        chk("ill_ready", b0.req_ready, 4'b0100);
        tick();
        chk("ill_q",   b0.flag_q, 64'h002E);
        chk("ill_err", b0.err, 1);
        chk("ill_eid", b0.err_id, 2);
        chk("ill_gv",  b0.grant_valid, 1);
        chk("ill_gid", b0.grant_id, 2);
        set0(2, 1'b0, SR_HOLD, 4'd0);
        tick();
        chk("ill_err_end", b0.err, 0);
        chk("ill_gv_end",  b0.grant_valid, 0);

        // out-of-range index on the 12-flag bank, then its top legal index
        set1(1, 1'b1, SR_SET, 4'd14);
        #1;
        chk("oor_ready", b1.req_ready, 4'b0010);
        tick();
        chk("oor_q",   b1.flag_q, 64'h000);
        chk("oor_err", b1.err, 1);
        chk("oor_eid", b1.err_id, 1);
        chk("oor_gv",  b1.grant_valid, 1);
        set1(1, 1'b1, SR_SET, 4'd11);
        tick();
        chk("top_q",   b1.flag_q, 64'h800);
        chk("top_qn",  b1.flag_qn, 64'h7FF);
        chk("top_err", b1.err, 0);
        set1(1, 1'b0, SR_HOLD, 4'd0);

        // fill the bank; last command from requester 3 leaves the pointer at 0
        for (int f = 0; f < 15; f++) begin
            set0(0, 1'b1, SR_SET, 4'(f));
            tick();
        end
        set0(0, 1'b0, SR_HOLD, 4'd0);
        set0(3, 1'b1, SR_SET, 4'd15);
        tick();
        set0(3, 1'b0, SR_HOLD, 4'd0);
        chk("fill_q", b0.flag_q, 64'hFFFF);

        // clr_all priority
        b0.clr_all = 1'b1;
        set0(0, 1'b1, SR_RESET, 4'd0);
        set0(3, 1'b1, SR_HOLD, 4'd0);
        #1;
        chk("clr_ready", b0.req_ready, 0);
        tick();
        chk("clr_q",  b0.flag_q, 64'h0);
        chk("clr_gv", b0.grant_valid, 0);
        b0.clr_all = 1'b0;
        #1;
        chk("post_clr_ready", b0.req_ready, 4'b0001);
        tick();
        chk("post_clr_gid", b0.grant_id, 0);
        chk("post_clr_gv",  b0.grant_valid, 1);
        set0(0, 1'b0, SR_HOLD, 4'd0);
        tick();
        set0(3, 1'b0, SR_HOLD, 4'd0);

        // async reset in the middle of back-to-back sets
        set0(0, 1'b1, SR_SET, 4'd7);
        set0(1, 1'b1, SR_SET, 4'd8);
        set0(2, 1'b1, SR_SET, 4'd9);
        tick();
        chk("b2b_q0", b0.flag_q, 64'h0080);
        tick();
        chk("b2b_q1", b0.flag_q, 64'h0180);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_q",     b0.flag_q, 64'h0);
        chk("arst_qn",    b0.flag_qn, 64'hFFFF);
        chk("arst_ready", b0.req_ready, 0);
        chk("arst_gv",    b0.grant_valid, 0);
        rst = 1'b1;
        #1;
        chk("restart_ready", b0.req_ready, 4'b0001);
        tick();
        chk("restart_gid", b0.grant_id, 0);
        chk("restart_q",   b0.flag_q, 64'h0080);
        b0.req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
